// File: rtl/counter_rr_scheduler.sv
// counter_rr_scheduler
//   Shares one N-bit interval counter among R requesters using round-robin
//   arbitration. The winning requester gets the counter for term+1 enabled
//   ticks. When the count finishes, the owner receives a one-cycle done pulse.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   req    : [R]   per-requester request level (hold until done, drop to abort)
//   term   : [R*N] per-requester terminal count, slice i = term[i*N +: N]
//   tick   : count enable
//   grant  : [R]   one-hot owner of the counter (registered)
//   busy   : high while the counter is running (registered)
//   count  : [N]   current counter value (registered)
//   done   : [R]   one-hot one-cycle completion pulse (registered)
module counter_rr_scheduler #(
  parameter int N = 7,
  parameter int R = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] term,
  input  logic           tick,
  output logic [R-1:0]   grant,
  output logic           busy,
  output logic [N-1:0]   count,
  output logic [R-1:0]   done
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [R-1:0]    grant_d, done_d;
  logic            busy_d;
  logic [N-1:0]    count_d;
  logic [N-1:0]    term_q, term_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;

  logic            found;
  logic [PW-1:0]   win;
  logic [N-1:0]    win_term;
  int              idx;

  function automatic logic [R-1:0] onehot(input logic [PW-1:0] sel);
    logic [R-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Round-robin search: the first set request after the pointer wins, so the
  // most recent owner is always the last one considered.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_term = '0;
    idx      = 0;
    for (int k = 1; k <= R; k++) begin
      idx = (int'(ptr_q) + k) % R;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    for (int i = 0; i < R; i++) begin
      if (int'(win) == i) win_term = term[i*N +: N];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    done_d  = '0;
    busy_d  = busy;
    count_d = count;
    term_d  = term_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (found) begin
          term_d  = win_term;
          owner_d = win;
          grant_d = onehot(win);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[owner_q]) begin
          // Abort: release the counter silently and rotate priority.
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = owner_q;
        end else if (tick && (count == term_q)) begin
          state_d = DONE;
          done_d  = onehot(owner_q);
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = owner_q;
        end else if (tick) begin
          count_d = count + 1'b1;
        end
      end
      DONE: begin
        // Requests are ignored here; this cycle only lets done drop.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      count   <= '0;
      ptr_q   <= PW'(R - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
      count   <= count_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // The terminal count is captured at grant time, so later term changes are
  // ignored. It is only read while RUN, so it needs no reset.
  always_ff @(posedge clk) begin
    term_q <= term_d;
  end

endmodule

// File: tb/tb_counter_rr_scheduler.sv
module tb_counter_rr_scheduler;
  localparam int N = 7;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req;
  logic [R*N-1:0] term;
  logic           tick;
  logic [R-1:0]   grant;
  logic           busy;
  logic [N-1:0]   count;
  logic [R-1:0]   done;

  always #5 clk = ~clk;

  counter_rr_scheduler #(.N(N), .R(R)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .term  (term),
    .tick  (tick),
    .grant (grant),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the counter (-1 = nobody), how far it has
  // counted, its latched target, who owned it last (lowest priority), and
  // who is receiving a done pulse this cycle (-1 = nobody).
  int m_owner = -1;
  int m_cnt   = 0;
  int m_T     = 0;
  int m_last  = R - 1;
  int m_done  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_term(input int i, input int v);
    term[i*N +: N] = N'(v);
  endtask

  task automatic model_step();
    int c;
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_last = R - 1; m_done = -1;
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (m_owner < 0) begin
      for (int j = 1; j <= R; j++) begin
        c = (m_last + j) % R;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_T     = int'(term >> (c * N)) & ((1 << N) - 1);
          m_cnt   = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_cnt = 0;
    end else if (tick) begin
      if (m_cnt == m_T) begin
        m_done = m_owner; m_last = m_owner; m_owner = -1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cycle();
    logic [31:0] eg, ed;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    ed = (m_done  >= 0) ? (32'd1 << m_done)  : 32'd0;
    check("grant", 32'(grant), eg);
    check("done",  32'(done),  ed);
    check("busy",  32'(busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
    check("count", 32'(count), 32'(m_cnt));
    check("grant_done_excl", 32'(grant & done), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  int order[$];
  logic [R-1:0] prev_grant;
  int n;
  int maxc;
  bit seen;

  initial begin
    reset = 1'b1; req = '0; term = '0; tick = 1'b0;

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_count", 32'(count), 32'd0);

    // Single requester, term 3, tick always high
    req = 4'b0001; set_term(0, 3); tick = 1'b1;
    cycle();
    check("t1_first_grant", 32'(grant), 32'd1);
    check("t1_first_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    check("t1_last_count", 32'(count), 32'd3);
    cycle();
    check("t1_done", 32'(done), 32'd1);
    req = '0;
    cycle();
    check("t1_done_drop", 32'(done), 32'd0);
    cycle();

    // All requesters, all terms 0: rotate 0,1,2,3,0
    do_reset();
    req = 4'b1111; term = '0; tick = 1'b1;
    prev_grant = '0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (grant != '0 && grant != prev_grant) order.push_back($clog2(grant));
      prev_grant = grant;
    end
    check("rr_n", 32'(order.size()) >= 32'd5 ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check("rr_order", 32'(order[i]), 32'(i % R));

    // Toggling tick, term 5
    do_reset();
    req = 4'b0001; set_term(0, 5);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick = (i % 2 == 1);
      cycle();
      if (done[0]) seen = 1'b1;
    end
    check("tog_done_seen", 32'(seen), 32'd1);
    req = '0; tick = 1'b1; cycle();

    // Abort at count 4 while requester 2 waits
    do_reset();
    req = 4'b0101; set_term(0, 10); set_term(2, 2); tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle();
      if (grant == 4'b0001 && count == 4) seen = 1'b1;
    end
    check("abort_reach4", 32'(seen), 32'd1);
    req = 4'b0100;
    cycle();
    check("abort_grant0", 32'(grant), 32'd0);
    check("abort_nodone", 32'(done), 32'd0);
    cycle();
    check("abort_next", 32'(grant), 32'b0100);
    req = '0;
    for (int i = 0; i < 6; i++) cycle();

    // All-ones terminal count, term changed mid-run
    do_reset();
    req = 4'b0001; set_term(0, (1 << N) - 1); tick = 1'b1;
    maxc = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cycle();
      if (i == 3) set_term(0, 2);
      if (int'(count) > maxc) maxc = int'(count);
      if (done[0]) seen = 1'b1;
    end
    check("full_done_seen", 32'(seen), 32'd1);
    check("full_max", 32'(maxc), 32'((1 << N) - 1));
    check("full_cleared", 32'(count), 32'd0);
    req = '0; cycle(); cycle();

    // Reset mid-run, then requester 0 wins first
    do_reset();
    req = 4'b0010; set_term(1, 9); tick = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle();
      if (grant == 4'b0010 && count == 5) seen = 1'b1;
    end
    check("mid_reach5", 32'(seen), 32'd1);
    reset = 1'b1;
    cycle();
    check("mid_grant", 32'(grant), 32'd0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_busy",  32'(busy),  32'd0);
    check("mid_done",  32'(done),  32'd0);
    reset = 1'b0; req = 4'b1111; term = '0;
    cycle();
    check("mid_first_winner", 32'(grant), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < R; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      for (int b = 0; b < R; b++)
        if ($urandom_range(0, 3) == 0) set_term(b, $urandom_range(0, 6));
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_rr_scheduler.md
# counter_rr_scheduler

Round-robin scheduler that shares one N-bit interval counter among R requesters. Each requester asks for an interval of `term+1` enabled ticks. The block grants the counter to one requester at a time, runs the count under a tick enable, and returns a one-cycle done pulse to the owner. It sits between the timing clients and the shared counter datapath and owns that counter's register.

## Interface
- `N`, default 7: counter width in bits.
- `R`, default 4: number of requesters; must be ≥ 2.
- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `req`  input  R  per-requester request level; held until done, or dropped to abort.
- `term`  input  R*N  per-requester terminal count; slice i is `term[i*N +: N]`.
- `tick`  input  1  count enable; the counter advances only when high.
- `grant`  output  R  one-hot owner of the counter; all zero when no owner.
- `busy`  output  1  high while in RUN.
- `count`  output  N  current counter value.
- `done`  output  R  one-hot, one-cycle completion pulse to the owner.

## Operation
- State machine: IDLE, RUN, DONE. All outputs are registered.
- Reset (takes priority over everything, in any state including mid-RUN):
  - state=IDLE; grant=0; done=0; busy=0; count=0.
  - Round-robin pointer ptr=R-1, so requester 0 has highest priority first.
- IDLE:
  - If no `req` bit is set, stay in IDLE.
  - Otherwise pick a winner: the first set `req` bit searching ptr+1, ptr+2, … modulo R.
  - On the same edge: latch the winner's `term` slice into internal `term_q`; set `grant`=onehot(winner); set count=0; set busy=1; go to RUN.
- RUN, checked in priority order:
  1. `req[owner]`=0: abort. Go to IDLE; grant=0, busy=0, count=0; no done pulse; ptr=owner.
  2. `tick`=1 and count==term_q: go to DONE; done=onehot(owner), grant=0, busy=0, count=0; ptr=owner.
  3. `tick`=1: count=count+1.
  4. `tick`=0: hold all state.
- DONE: lasts one cycle. done returns to 0, go to IDLE. `req` is not sampled in DONE.
- `term` changes after the grant edge have no effect, because `term_q` is latched at grant.
- term=0 is legal: done fires on the first enabled tick.
- term=2^N-1 is legal: count reaches all-ones and then clears through DONE. Count never wraps inside RUN and never exceeds term_q.
- Fairness: after any completion or abort the owner becomes lowest priority. Other requesters are never starved.
- A requester that keeps `req` high after its done competes again from IDLE at its rotated priority.
- At most one bit of `grant` is set, and at most one bit of `done` is set. `grant` and `done` are never high in the same cycle.

## Timing
- `req` seen high in IDLE at edge k → grant/busy high from cycle k+1, with count=0.
- With `tick` held high and term_q=T, the RUN state spans T+1 cycles (count 0..T). done is high in cycle T+1 after the grant cycle.
- done → next grant minimum is 2 cycles (DONE, then IDLE).
- An abort returns to IDLE in 1 cycle. A new grant can follow 1 cycle later.
- tick low stretches RUN cycle-for-cycle; no tick is lost or double-counted.
- Reset asserted mid-RUN: all outputs reach reset values on the next edge and no done is emitted.

## Test plan
- Reset, then req=0001, term0=3, tick=1 continuously → grant=0001 for 4 cycles with count 0,1,2,3; then done=0001 for one cycle; then grant=0, count=0.
- req=1111, all terms 0, tick=1, req held → grants in order 0,1,2,3,0 with a 3-cycle period each (RUN, DONE, IDLE). done order matches the grant order.
- req0 granted with term0=5, tick toggling 1,0,1,0… → count advances only on tick-high cycles. done arrives on the 6th tick.
- req0 granted with term0=10; drop req0 at count=4 while req2 is high → grant=0 and no done pulse; grant=0100 two cycles later.
- N=3, term=7, tick=1 → count runs 0..7, done pulses, count returns to 0 with no intermediate wrap. Changing term0 to 2 mid-RUN has no effect.
- Assert reset while count=5 and grant=0010 → next cycle grant=0, count=0, busy=0, done=0. After release with req=1111, requester 0 wins first.
